// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the hazard controller slice:
// register-index and Tnew/Tuse widths, the "not used" Tuse code and md latencies.
package pipe_pkg;

   localparam int REG_W = 5;
   localparam int T_W   = 2;

   localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

   localparam int MULT_CYCLES_DFLT = 5;
   localparam int DIV_CYCLES_DFLT  = 10;
   localparam int CNT_W_DFLT       = 4;

   typedef logic [REG_W-1:0] reg_idx_t;
   typedef logic [T_W-1:0]   tstage_t;

   // One bit per hazard source; any set bit freezes the front end.
   typedef struct packed {
      logic rs_e;
      logic rs_m;
      logic rt_e;
      logic rt_m;
      logic md;
   } hazard_t;

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy window: loads the op latency on start, counts down to 0,
// and reports busy for the start cycle plus every nonzero-count cycle.
module md_busy_ctr #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sel_div,
   output logic             busy,
   output logic [CNT_W-1:0] remaining
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         // A start always reloads, even if a window is already open.
         cnt_d = sel_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments and a synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy      = !reset && (start || (cnt_q != '0));
   assign remaining = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/bubble controller: compares D-stage Tuse against E/M producer Tnew,
// blocks md instructions while the mult/div unit is busy, and counts stalled cycles.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DFLT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DFLT,
   parameter int CNT_W       = CNT_W_DFLT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_W-1:0]     D_rs,
   input  logic [REG_W-1:0]     D_rt,
   input  logic [T_W-1:0]       Tuse_rs,
   input  logic [T_W-1:0]       Tuse_rt,
   input  logic                 D_md_use,
   input  logic [REG_W-1:0]     E_GRF_WA,
   input  logic [T_W-1:0]       Tnew_E,
   input  logic [REG_W-1:0]     M_GRF_WA,
   input  logic [T_W-1:0]       Tnew_M,
   input  logic                 E_md_start,
   input  logic                 E_md_div,
   output logic                 stall,
   output logic                 E_clr,
   output logic                 md_busy,
   output logic [CNT_W-1:0]     md_remaining,
   output logic [31:0]          stall_cnt
);

   hazard_t     haz;
   logic [31:0] stall_cnt_d;
   logic [31:0] stall_cnt_q;

   // The E stage is never frozen, so a start is honoured even in a stalled cycle.
   md_busy_ctr #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_ctr (
      .clk       (clk),
      .reset     (reset),
      .start     (E_md_start),
      .sel_div   (E_md_div),
      .busy      (md_busy),
      .remaining (md_remaining)
   );

   always_comb begin
      haz = '0;
      if (!reset) begin
         // $0 is hard-wired, and a source that is never read cannot hazard.
         haz.rs_e = (D_rs != '0) && (Tuse_rs != TUSE_NONE) &&
                    (D_rs == E_GRF_WA) && (Tuse_rs < Tnew_E);
         haz.rs_m = (D_rs != '0) && (Tuse_rs != TUSE_NONE) &&
                    (D_rs == M_GRF_WA) && (Tuse_rs < Tnew_M);
         haz.rt_e = (D_rt != '0) && (Tuse_rt != TUSE_NONE) &&
                    (D_rt == E_GRF_WA) && (Tuse_rt < Tnew_E);
         haz.rt_m = (D_rt != '0) && (Tuse_rt != TUSE_NONE) &&
                    (D_rt == M_GRF_WA) && (Tuse_rt < Tnew_M);
         haz.md   = D_md_use && md_busy;
      end
   end

   assign stall = |haz;
   assign E_clr = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives one cycle of stimulus, queues
// the expected outputs, and pops them for comparison at the following negedge.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  D_rs, D_rt, E_GRF_WA, M_GRF_WA;
   logic [1:0]  Tuse_rs, Tuse_rt, Tnew_E, Tnew_M;
   logic        D_md_use, E_md_start, E_md_div;
   logic        stall, E_clr, md_busy;
   logic [3:0]  md_remaining;
   logic [31:0] stall_cnt;

   hazard_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .D_rs         (D_rs),
      .D_rt         (D_rt),
      .Tuse_rs      (Tuse_rs),
      .Tuse_rt      (Tuse_rt),
      .D_md_use     (D_md_use),
      .E_GRF_WA     (E_GRF_WA),
      .Tnew_E       (Tnew_E),
      .M_GRF_WA     (M_GRF_WA),
      .Tnew_M       (Tnew_M),
      .E_md_start   (E_md_start),
      .E_md_div     (E_md_div),
      .stall        (stall),
      .E_clr        (E_clr),
      .md_busy      (md_busy),
      .md_remaining (md_remaining),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        st;
      logic        busy;
      logic [3:0]  rem;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_cnt = '0;

   task automatic set_reg(input logic [4:0] rs, input logic [1:0] urs,
                          input logic [4:0] rt, input logic [1:0] urt,
                          input logic [4:0] ewa, input logic [1:0] te,
                          input logic [4:0] mwa, input logic [1:0] tm);
      D_rs = rs; Tuse_rs = urs; D_rt = rt; Tuse_rt = urt;
      E_GRF_WA = ewa; Tnew_E = te; M_GRF_WA = mwa; Tnew_M = tm;
   endtask

   task automatic set_md(input logic use_md, input logic start, input logic dv);
      D_md_use = use_md; E_md_start = start; E_md_div = dv;
   endtask

   task automatic idle_reg();
      set_reg(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0, 5'd0, 2'd0);
   endtask

   // Inputs are already driven for this cycle; queue what the DUT must show.
   task automatic step(input string tag, input logic st, input logic busy, input logic [3:0] rem);
      exp_t e;
      e.tag = tag; e.st = st; e.busy = busy; e.rem = rem; e.cnt = model_cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      assert (stall === e.st) else begin
         errors++; $error("FAIL %s stall: got %0b expected %0b", e.tag, stall, e.st);
      end
      checks++;
      assert (E_clr === e.st) else begin
         errors++; $error("FAIL %s E_clr: got %0b expected %0b", e.tag, E_clr, e.st);
      end
      checks++;
      assert (md_busy === e.busy) else begin
         errors++; $error("FAIL %s md_busy: got %0b expected %0b", e.tag, md_busy, e.busy);
      end
      checks++;
      assert (md_remaining === e.rem) else begin
         errors++; $error("FAIL %s md_remaining: got %0d expected %0d", e.tag, md_remaining, e.rem);
      end
      checks++;
      assert (stall_cnt === e.cnt) else begin
         errors++; $error("FAIL %s stall_cnt: got %0h expected %0h", e.tag, stall_cnt, e.cnt);
      end
      @(posedge clk);
      if (reset) model_cnt = '0;
      else if (e.st && (model_cnt != 32'hFFFF_FFFF)) model_cnt = model_cnt + 32'd1;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle_reg();
      set_md(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // Reset masks both a register hazard and an md start.
      set_reg(5'd1, 2'd1, 5'd0, TUSE_NONE, 5'd1, 2'd2, 5'd0, 2'd0);
      set_md(1'b1, 1'b1, 1'b0);
      step("reset_mask", 1'b0, 1'b0, 4'd0);

      reset = 1'b0;
      idle_reg();
      set_md(1'b0, 1'b0, 1'b0);
      step("idle", 1'b0, 1'b0, 4'd0);

      set_reg(5'd1, 2'd1, 5'd0, TUSE_NONE, 5'd1, 2'd2, 5'd0, 2'd0);
      step("lw_use_E", 1'b1, 1'b0, 4'd0);
      set_reg(5'd1, 2'd1, 5'd0, TUSE_NONE, 5'd1, 2'd0, 5'd1, 2'd1);
      step("lw_in_M", 1'b0, 1'b0, 4'd0);
      set_reg(5'd0, TUSE_NONE, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd1);
      step("rt_M", 1'b1, 1'b0, 4'd0);
      set_reg(5'd0, 2'd0, 5'd0, TUSE_NONE, 5'd0, 2'd2, 5'd0, 2'd0);
      step("reg0", 1'b0, 1'b0, 4'd0);
      set_reg(5'd3, 2'd0, 5'd3, 2'd0, 5'd3, 2'd2, 5'd0, 2'd0);
      step("rs_eq_rt", 1'b1, 1'b0, 4'd0);
      set_reg(5'd4, 2'd2, 5'd0, TUSE_NONE, 5'd4, 2'd2, 5'd0, 2'd0);
      step("tuse_eq_tnew", 1'b0, 1'b0, 4'd0);
      set_reg(5'd5, 2'd0, 5'd0, TUSE_NONE, 5'd5, 2'd1, 5'd5, 2'd0);
      step("E_and_M_same", 1'b1, 1'b0, 4'd0);
      set_reg(5'd6, TUSE_NONE, 5'd0, TUSE_NONE, 5'd6, 2'd2, 5'd0, 2'd0);
      step("tuse_none", 1'b0, 1'b0, 4'd0);

      // Multiply window with an md instruction waiting in D.
      idle_reg();
      set_md(1'b1, 1'b1, 1'b0);
      step("mult_start", 1'b1, 1'b1, 4'd0);
      set_md(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step($sformatf("mult_c%0d", i), 1'b1, 1'b1, 4'(6 - i));
      end
      step("mult_issue", 1'b0, 1'b0, 4'd0);

      // A forced start mid-window reloads instead of decrementing.
      set_md(1'b0, 1'b1, 1'b0);
      step("sw_start", 1'b0, 1'b1, 4'd0);
      set_md(1'b0, 1'b0, 1'b0);
      step("sw_c1", 1'b0, 1'b1, 4'd5);
      step("sw_c2", 1'b0, 1'b1, 4'd4);
      set_md(1'b0, 1'b1, 1'b0);
      step("sw_force", 1'b0, 1'b1, 4'd3);
      set_md(1'b0, 1'b0, 1'b0);
      for (int i = 5; i >= 1; i--) begin
         step($sformatf("sw_reload%0d", i), 1'b0, 1'b1, 4'(i));
      end
      step("sw_done", 1'b0, 1'b0, 4'd0);

      // Divide window interrupted by reset when six cycles remain.
      set_md(1'b1, 1'b1, 1'b1);
      step("div_start", 1'b1, 1'b1, 4'd0);
      set_md(1'b1, 1'b0, 1'b0);
      for (int i = 10; i >= 7; i--) begin
         step($sformatf("div_c%0d", i), 1'b1, 1'b1, 4'(i));
      end
      reset = 1'b1;
      step("div_rst", 1'b0, 1'b0, 4'd6);
      reset = 1'b0;
      step("div_after_rst", 1'b0, 1'b0, 4'd0);

      // Saturation: preload just below the ceiling, then keep stalling.
      set_md(1'b0, 1'b0, 1'b0);
      idle_reg();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.stall_cnt_q;
      @(posedge clk);
      #1;
      model_cnt = 32'hFFFF_FFFE;
      set_reg(5'd2, 2'd0, 5'd0, TUSE_NONE, 5'd2, 2'd1, 5'd0, 2'd0);
      step("sat_fe", 1'b1, 1'b0, 4'd0);
      step("sat_ff", 1'b1, 1'b0, 4'd0);
      step("sat_hold", 1'b1, 1'b0, 4'd0);
      idle_reg();
      step("sat_idle", 1'b0, 1'b0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
